// File: rtl/cgra_lsu_pkg.sv
// ---------------------------------------------------------------------------
// cgra_lsu_pkg
// Shared definitions for the CGRA load/store arbiter:
//   lsu_state_e  - arbiter FSM states (IDLE, REQ, WAIT)
//   MEM_BE_ALL   - byte-enable value for full-word accesses
//   idx_width()  - width of a tile index for a given tile count
// ---------------------------------------------------------------------------
package cgra_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  localparam logic [3:0] MEM_BE_ALL = 4'hF;

  // A single-tile grid still needs a 1-bit index signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_pe.sv
// ---------------------------------------------------------------------------
// rr_arbiter_pe
// Purely combinational round-robin picker. Scans the request vector starting
// at the pointer index and wrapping past N-1 back to 0.
// Ports:
//   req    in  N   request vector, one bit per tile
//   ptr    in  IW  index with the highest priority
//   winner out IW  index of the selected requester (0 when none)
//   valid  out 1   at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter_pe
  import cgra_lsu_pkg::*;
#(
  parameter int N  = 16,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          valid
);

  // Walk the offsets from farthest to nearest so the requester closest to
  // the pointer is written last and therefore wins.
  always_comb begin : pick
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (req[IW'(idx)]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cgra_lsu_arbiter.sv
// ---------------------------------------------------------------------------
// cgra_lsu_arbiter
// Shares one memory port among the N = NB_ROWS*NB_COLS tiles of a CGRA.
// One transaction is outstanding at a time: a requester is picked
// round-robin in IDLE, its fields are latched, the request is presented in
// REQ until accepted, and the response is awaited in WAIT.
// Ports:
//   Clk, Reset (async, active-low)
//   Tile_Req_I/We_I [N], Tile_Addr_I/Wdata_I [N*DWIDTH]  tile requests
//   Tile_Grant_O/Rvalid_O [N] one-hot pulses, Tile_Rdata_O load data
//   Mem_Req_O/We_O/Addr_O/Wdata_O/Be_O                   memory request
//   Mem_Gnt_I/Rvalid_I/Rdata_I                           memory response
//   Busy_O  high while a transaction is in flight
// ---------------------------------------------------------------------------
module cgra_lsu_arbiter
  import cgra_lsu_pkg::*;
#(
  parameter  int NB_ROWS = 4,
  parameter  int NB_COLS = 4,
  parameter  int DWIDTH  = 32,
  localparam int N       = NB_ROWS * NB_COLS
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N-1:0]        Tile_Req_I,
  input  logic [N-1:0]        Tile_We_I,
  input  logic [N*DWIDTH-1:0] Tile_Addr_I,
  input  logic [N*DWIDTH-1:0] Tile_Wdata_I,
  output logic [N-1:0]        Tile_Grant_O,
  output logic [N-1:0]        Tile_Rvalid_O,
  output logic [DWIDTH-1:0]   Tile_Rdata_O,
  output logic                Mem_Req_O,
  output logic                Mem_We_O,
  output logic [DWIDTH-1:0]   Mem_Addr_O,
  output logic [DWIDTH-1:0]   Mem_Wdata_O,
  output logic [3:0]          Mem_Be_O,
  input  logic                Mem_Gnt_I,
  input  logic                Mem_Rvalid_I,
  input  logic [DWIDTH-1:0]   Mem_Rdata_I,
  output logic                Busy_O
);

  localparam int            IW      = idx_width(N);
  localparam logic [N-1:0]  ONE_HOT = N'(1);
  localparam logic [IW-1:0] LAST    = IW'(N - 1);

  lsu_state_e        state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     winner;
  logic              we_q;
  logic [DWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [N-1:0]      grant_q;
  logic [N-1:0]      rvalid_q;
  logic [DWIDTH-1:0] rdata_q;

  logic [IW-1:0]     sel_idx;
  logic              sel_valid;
  logic [DWIDTH-1:0] tile_addr  [N];
  logic [DWIDTH-1:0] tile_wdata [N];

  // Unpack the flat per-tile buses so the winner can index them directly.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      tile_addr[i]  = Tile_Addr_I[i*DWIDTH +: DWIDTH];
      tile_wdata[i] = Tile_Wdata_I[i*DWIDTH +: DWIDTH];
    end
  end

  rr_arbiter_pe #(
    .N  (N),
    .IW (IW)
  ) u_rr (
    .req    (Tile_Req_I),
    .ptr    (rr_ptr),
    .winner (sel_idx),
    .valid  (sel_valid)
  );

  // Transaction FSM. The request fields are captured once in IDLE so later
  // tile-side activity, including a withdrawn request, cannot disturb the
  // transaction. Grant and response pulses default low each cycle, which
  // keeps them single-cycle and one-hot.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      winner   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      grant_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      grant_q  <= '0;
      rvalid_q <= '0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            winner  <= sel_idx;
            we_q    <= Tile_We_I[sel_idx];
            addr_q  <= tile_addr[sel_idx];
            wdata_q <= tile_wdata[sel_idx];
            state   <= REQ;
          end
        end
        REQ: begin
          if (Mem_Gnt_I) begin
            grant_q <= ONE_HOT << winner;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (Mem_Rvalid_I) begin
            rvalid_q <= ONE_HOT << winner;
            if (!we_q) begin
              rdata_q <= Mem_Rdata_I;
            end
            rr_ptr <= (winner == LAST) ? '0 : winner + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side fields are gated so the bus reads zero outside REQ.
  always_comb begin
    Mem_Req_O   = (state == REQ);
    Mem_We_O    = (state == REQ) && we_q;
    Mem_Addr_O  = (state == REQ) ? addr_q  : '0;
    Mem_Wdata_O = (state == REQ) ? wdata_q : '0;
  end

  assign Mem_Be_O      = MEM_BE_ALL;
  assign Busy_O        = (state != IDLE);
  assign Tile_Grant_O  = grant_q;
  assign Tile_Rvalid_O = rvalid_q;
  assign Tile_Rdata_O  = rdata_q;

endmodule

// File: tb/tb_cgra_lsu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cgra_lsu_arbiter
// Self-checking bench for cgra_lsu_arbiter (4x4 grid, 32-bit data). A
// transaction-level model tracks the round-robin pointer and the last load
// data; directed and randomized transactions are compared against it.
// ---------------------------------------------------------------------------
module tb_cgra_lsu_arbiter;

  localparam int N  = 16;
  localparam int DW = 32;

  logic            Clk;
  logic            Reset;
  logic [N-1:0]    Tile_Req_I;
  logic [N-1:0]    Tile_We_I;
  logic [N*DW-1:0] Tile_Addr_I;
  logic [N*DW-1:0] Tile_Wdata_I;
  logic [N-1:0]    Tile_Grant_O;
  logic [N-1:0]    Tile_Rvalid_O;
  logic [DW-1:0]   Tile_Rdata_O;
  logic            Mem_Req_O;
  logic            Mem_We_O;
  logic [DW-1:0]   Mem_Addr_O;
  logic [DW-1:0]   Mem_Wdata_O;
  logic [3:0]      Mem_Be_O;
  logic            Mem_Gnt_I;
  logic            Mem_Rvalid_I;
  logic [DW-1:0]   Mem_Rdata_I;
  logic            Busy_O;

  cgra_lsu_arbiter #(
    .NB_ROWS (4),
    .NB_COLS (4),
    .DWIDTH  (DW)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Tile_Req_I    (Tile_Req_I),
    .Tile_We_I     (Tile_We_I),
    .Tile_Addr_I   (Tile_Addr_I),
    .Tile_Wdata_I  (Tile_Wdata_I),
    .Tile_Grant_O  (Tile_Grant_O),
    .Tile_Rvalid_O (Tile_Rvalid_O),
    .Tile_Rdata_O  (Tile_Rdata_O),
    .Mem_Req_O     (Mem_Req_O),
    .Mem_We_O      (Mem_We_O),
    .Mem_Addr_O    (Mem_Addr_O),
    .Mem_Wdata_O   (Mem_Wdata_O),
    .Mem_Be_O      (Mem_Be_O),
    .Mem_Gnt_I     (Mem_Gnt_I),
    .Mem_Rvalid_I  (Mem_Rvalid_I),
    .Mem_Rdata_I   (Mem_Rdata_I),
    .Busy_O        (Busy_O)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checkCount = 0;
  int passCount  = 0;

  logic [N-1:0]  reqV;
  logic [N-1:0]  weV;
  logic [DW-1:0] addrV  [N];
  logic [DW-1:0] wdataV [N];

  int            rrPtrModel = 0;
  logic [DW-1:0] rdataModel = '0;
  int            served [N];
  int            lastWin;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus();
    Tile_Req_I = reqV;
    Tile_We_I  = weV;
    for (int i = 0; i < N; i++) begin
      Tile_Addr_I[i*DW +: DW]  = addrV[i];
      Tile_Wdata_I[i*DW +: DW] = wdataV[i];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Model: order the tiles starting at the pointer and take the first one
  // that is requesting.
  function automatic int pickWinner(input logic [N-1:0] req, input int ptr);
    int order[$];
    int cand;
    for (int k = 0; k < N; k++) order.push_back((ptr + k) % N);
    while (order.size() > 0) begin
      cand = order.pop_front();
      if (req[cand]) return cand;
    end
    return -1;
  endfunction

  task automatic randomizeTiles();
    reqV = N'($urandom);
    weV  = N'($urandom);
    for (int i = 0; i < N; i++) begin
      addrV[i]  = $urandom & 32'hFFFF_FFFC;
      wdataV[i] = $urandom;
    end
  endtask

  // One complete transaction: issue, hold off the grant for gntDelay
  // cycles, then delay the response by rvDelay cycles after the grant.
  task automatic runTransaction(input int gntDelay, input int rvDelay,
                                input bit scramble, input logic [DW-1:0] rdataIn,
                                output int win);
    logic          expWe;
    logic [DW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    logic [31:0]   expOh;
    win      = pickWinner(reqV, rrPtrModel);
    expWe    = weV[win];
    expAddr  = addrV[win];
    expWdata = wdataV[win];
    expOh    = 32'd1 << win;
    applyStimulus();
    tick();
    checkOutput("rvalid_cleared", Tile_Rvalid_O, 0);
    for (int c = 0; c <= gntDelay; c++) begin
      checkOutput("mem_req", Mem_Req_O, 1);
      checkOutput("mem_we", Mem_We_O, expWe);
      checkOutput("mem_addr", Mem_Addr_O, expAddr);
      checkOutput("mem_wdata", Mem_Wdata_O, expWdata);
      checkOutput("mem_be", Mem_Be_O, 4'hF);
      checkOutput("busy_req", Busy_O, 1);
      checkOutput("grant_idle", Tile_Grant_O, 0);
      checkOutput("rvalid_req", Tile_Rvalid_O, 0);
      if (scramble) begin
        randomizeTiles();
        applyStimulus();
        Mem_Rvalid_I = 1'($urandom_range(0, 1));
      end
      Mem_Gnt_I = (c == gntDelay);
      tick();
    end
    Mem_Gnt_I    = 1'b0;
    Mem_Rvalid_I = 1'b0;
    checkOutput("grant_pulse", Tile_Grant_O, expOh);
    checkOutput("mem_req_off", Mem_Req_O, 0);
    checkOutput("mem_addr_off", Mem_Addr_O, 0);
    checkOutput("mem_wdata_off", Mem_Wdata_O, 0);
    checkOutput("mem_we_off", Mem_We_O, 0);
    checkOutput("busy_wait", Busy_O, 1);
    checkOutput("rvalid_early", Tile_Rvalid_O, 0);
    for (int c = 0; c <= rvDelay; c++) begin
      if (c == rvDelay) begin
        Mem_Rvalid_I = 1'b1;
        Mem_Rdata_I  = rdataIn;
      end
      tick();
      if (c < rvDelay) begin
        checkOutput("grant_once", Tile_Grant_O, 0);
        checkOutput("rvalid_wait", Tile_Rvalid_O, 0);
      end
    end
    Mem_Rvalid_I = 1'b0;
    if (!expWe) rdataModel = rdataIn;
    checkOutput("rvalid_pulse", Tile_Rvalid_O, expOh);
    checkOutput("rdata", Tile_Rdata_O, rdataModel);
    checkOutput("grant_after", Tile_Grant_O, 0);
    checkOutput("busy_done", Busy_O, 0);
    rrPtrModel = (win + 1) % N;
  endtask

  initial begin
    Reset        = 1'b0;
    Mem_Gnt_I    = 1'b0;
    Mem_Rvalid_I = 1'b0;
    Mem_Rdata_I  = '0;
    reqV = '0;
    weV  = '0;
    for (int i = 0; i < N; i++) begin
      addrV[i]  = '0;
      wdataV[i] = '0;
    end
    applyStimulus();

    #7;
    checkOutput("rst_grant", Tile_Grant_O, 0);
    checkOutput("rst_rvalid", Tile_Rvalid_O, 0);
    checkOutput("rst_rdata", Tile_Rdata_O, 0);
    checkOutput("rst_mem_req", Mem_Req_O, 0);
    checkOutput("rst_mem_addr", Mem_Addr_O, 0);
    checkOutput("rst_busy", Busy_O, 0);
    tick();
    Reset = 1'b1;
    tick();
    checkOutput("idle_busy", Busy_O, 0);

    $display("[TB] single load, tile 5");
    reqV     = 16'h0020;
    weV      = '0;
    addrV[5] = 32'h0000_0100;
    runTransaction(1, 0, 1'b0, 32'hDEAD_BEEF, lastWin);
    checkOutput("load_winner", lastWin, 5);

    $display("[TB] store, tile 0");
    reqV      = 16'h0001;
    weV       = 16'h0001;
    addrV[0]  = 32'h0000_0040;
    wdataV[0] = 32'h1234_5678;
    runTransaction(0, 1, 1'b0, 32'hCAFE_F00D, lastWin);
    checkOutput("store_winner", lastWin, 0);
    checkOutput("store_rdata_kept", Tile_Rdata_O, 32'hDEAD_BEEF);

    $display("[TB] backpressure with tile-side toggling");
    randomizeTiles();
    reqV = reqV | 16'h8000;
    runTransaction(10, 2, 1'b1, $urandom, lastWin);

    $display("[TB] reset during WAIT");
    reqV     = 16'h0008;
    weV      = '0;
    addrV[3] = 32'h0000_0300;
    applyStimulus();
    tick();
    Mem_Gnt_I = 1'b1;
    tick();
    Mem_Gnt_I = 1'b0;
    checkOutput("midrst_grant", Tile_Grant_O, 16'h0008);
    #2;
    Reset = 1'b0;
    reqV  = '0;
    applyStimulus();
    #1;
    checkOutput("midrst_busy", Busy_O, 0);
    checkOutput("midrst_grant_clr", Tile_Grant_O, 0);
    checkOutput("midrst_rdata", Tile_Rdata_O, 0);
    tick();
    Reset        = 1'b1;
    rrPtrModel   = 0;
    rdataModel   = '0;
    Mem_Rvalid_I = 1'b1;
    Mem_Rdata_I  = 32'h5555_AAAA;
    tick();
    Mem_Rvalid_I = 1'b0;
    checkOutput("late_rvalid", Tile_Rvalid_O, 0);
    checkOutput("late_busy", Busy_O, 0);
    checkOutput("late_rdata", Tile_Rdata_O, 0);

    $display("[TB] fairness, all tiles requesting");
    for (int i = 0; i < N; i++) served[i] = 0;
    for (int t = 0; t <= N; t++) begin
      reqV = '1;
      weV  = N'($urandom);
      runTransaction(0, 0, 1'b0, $urandom, lastWin);
      checkOutput("fair_order", lastWin, t % N);
      if (t < N) served[lastWin]++;
    end
    for (int i = 0; i < N; i++) checkOutput("fair_count", served[i], 1);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 40; t++) begin
      randomizeTiles();
      if (reqV == '0) reqV[$urandom_range(0, N - 1)] = 1'b1;
      runTransaction($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, $urandom, lastWin);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
